// File: rtl/adc_trigger_capture.sv
// adc_trigger_capture: rising-edge triggered single-shot ADC frame capture into
// a DEPTH-word buffer that a VGA display side reads one column at a time.
// Optional build macro ADC_TRIG_TIMEOUT_EN enables an auto-trigger after
// TIMEOUT_SAMPLES valid samples spent waiting in ARMED.
module adc_trigger_capture #(
    parameter int DEPTH           = 640,
    parameter int TIMEOUT_SAMPLES = 4095
) (
    input  logic       Clk,
    input  logic       vgaRst,
    input  logic [7:0] adcData,
    input  logic       adcValid,
    input  logic [7:0] trigLevel,
    input  logic       arm,
    input  logic [9:0] rdAddr,
    output logic [7:0] rdData,
    output logic       frameReady,
    output logic       busy,
    output logic [9:0] adcToVgaCount
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam logic [10:0] DEPTH_L = 11'(DEPTH);

    state_t     state_r, state_s;
    logic [9:0] count_r, count_s;
    logic [7:0] prev_r, prev_s;
    logic       prev_vld_r, prev_vld_s;
    logic       wr_en_s;
    logic [9:0] wr_addr_s;
    logic       force_s;
    logic       hit_s;
    logic [7:0] rd_data_r;
    logic       frame_ready_r;
    logic       busy_r;
    logic [7:0] mem_r [0:DEPTH-1];

`ifdef ADC_TRIG_TIMEOUT_EN
    localparam logic [15:0] TMO_L = 16'(TIMEOUT_SAMPLES);
    logic [15:0] tmo_r, tmo_s;
    assign force_s = (tmo_r == TMO_L);
`else
    assign force_s = 1'b0;
`endif

    // Trigger condition: genuine rising crossing of trigLevel, or forced by timeout.
    assign hit_s = (prev_vld_r && (prev_r < trigLevel) && (adcData >= trigLevel)) || force_s;

    // Next-state, counter and write-port decode for the capture FSM.
    always_comb begin
        state_s    = state_r;
        count_s    = count_r;
        prev_s     = prev_r;
        prev_vld_s = prev_vld_r;
        wr_en_s    = 1'b0;
        wr_addr_s  = count_r;
`ifdef ADC_TRIG_TIMEOUT_EN
        tmo_s      = tmo_r;
`endif
        case (state_r)
            IDLE, DONE: begin
                if (arm) begin
                    state_s    = ARMED;
                    count_s    = 10'd0;
                    prev_vld_s = 1'b0;
`ifdef ADC_TRIG_TIMEOUT_EN
                    tmo_s      = 16'd0;
`endif
                end else begin
                    state_s = state_r;
                end
            end
            ARMED: begin
                if (adcValid) begin
                    prev_s     = adcData;
                    prev_vld_s = 1'b1;
                    if (hit_s) begin
                        wr_en_s   = 1'b1;
                        wr_addr_s = 10'd0;
                        count_s   = 10'd1;
                        state_s   = CAPTURE;
                    end else begin
`ifdef ADC_TRIG_TIMEOUT_EN
                        tmo_s = tmo_r + 16'd1;
`endif
                        state_s = ARMED;
                    end
                end else begin
                    state_s = ARMED;
                end
            end
            CAPTURE: begin
                if (adcValid) begin
                    wr_en_s   = 1'b1;
                    wr_addr_s = count_r;
                    count_s   = count_r + 10'd1;
                    if (({1'b0, count_r} + 11'd1) == DEPTH_L) begin
                        state_s = DONE;
                    end else begin
                        state_s = CAPTURE;
                    end
                end else begin
                    state_s = CAPTURE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State and control registers; status outputs registered from next state.
    always_ff @(posedge Clk) begin
        if (!vgaRst) begin
            state_r       <= IDLE;
            count_r       <= 10'd0;
            prev_r        <= 8'd0;
            prev_vld_r    <= 1'b0;
            frame_ready_r <= 1'b0;
            busy_r        <= 1'b0;
`ifdef ADC_TRIG_TIMEOUT_EN
            tmo_r         <= 16'd0;
`endif
        end else begin
            state_r       <= state_s;
            count_r       <= count_s;
            prev_r        <= prev_s;
            prev_vld_r    <= prev_vld_s;
            frame_ready_r <= (state_s == DONE);
            busy_r        <= (state_s == ARMED) || (state_s == CAPTURE);
`ifdef ADC_TRIG_TIMEOUT_EN
            tmo_r         <= tmo_s;
`endif
        end
    end

    // Sample buffer write port; contents survive reset, writes blocked while in reset.
    always_ff @(posedge Clk) begin
        if (vgaRst && wr_en_s) begin
            mem_r[wr_addr_s] <= adcData;
        end
    end

    // Registered read port; same-cycle write to the same word returns the old word.
    always_ff @(posedge Clk) begin
        if (!vgaRst) begin
            rd_data_r <= 8'd0;
        end else if ({1'b0, rdAddr} < DEPTH_L) begin
            rd_data_r <= mem_r[rdAddr];
        end else begin
            rd_data_r <= 8'd0;
        end
    end

    assign rdData        = rd_data_r;
    assign frameReady    = frame_ready_r;
    assign busy          = busy_r;
    assign adcToVgaCount = count_r;

endmodule

// File: tb/tb_adc_trigger_capture.sv
// Testbench for adc_trigger_capture: directed stimulus pushes expected read
// words and status tuples into queues; a monitor pops and compares them.
module tb_adc_trigger_capture;

    logic       Clk = 1'b0;
    logic       vgaRst;
    logic [7:0] adcData;
    logic       adcValid;
    logic [7:0] trigLevel;
    logic       arm;
    logic [9:0] rdAddr;
    logic [7:0] rdData;
    logic       frameReady;
    logic       busy;
    logic [9:0] adcToVgaCount;

    int n_tests = 0;
    int n_fail  = 0;

    logic [17:0] rd_q [$];   // {addr, expected word}
    logic [11:0] st_q [$];   // {frameReady, busy, count}
    logic        rd_req   = 1'b0;
    logic        rd_req_d = 1'b0;
    logic        st_req   = 1'b0;

    adc_trigger_capture dut (
        .Clk           (Clk),
        .vgaRst        (vgaRst),
        .adcData       (adcData),
        .adcValid      (adcValid),
        .trigLevel     (trigLevel),
        .arm           (arm),
        .rdAddr        (rdAddr),
        .rdData        (rdData),
        .frameReady    (frameReady),
        .busy          (busy),
        .adcToVgaCount (adcToVgaCount)
    );

    always #5 Clk = ~Clk;

    // Read data appears one edge after the address is presented.
    always @(posedge Clk) rd_req_d <= rd_req;

    // Monitor: compare DUT outputs with queued expectations.
    always @(negedge Clk) begin
        logic [17:0] r;
        logic [11:0] s;
        if (rd_req_d) begin
            n_tests++;
            if (rd_q.size() == 0) begin
                n_fail++;
                $display("FAIL rd_queue_empty: read presented with no expectation");
            end else begin
                r = rd_q.pop_front();
                if (rdData !== r[7:0]) begin
                    n_fail++;
                    $display("FAIL rd addr=%0d: got %0d expected %0d", r[17:8], rdData, r[7:0]);
                end
            end
        end
        if (st_req) begin
            n_tests++;
            if (st_q.size() == 0) begin
                n_fail++;
                $display("FAIL st_queue_empty: status check with no expectation");
            end else begin
                s = st_q.pop_front();
                if ({frameReady, busy, adcToVgaCount} !== s) begin
                    n_fail++;
                    $display("FAIL status: got fr=%0b busy=%0b cnt=%0d expected fr=%0b busy=%0b cnt=%0d",
                             frameReady, busy, adcToVgaCount, s[11], s[10], s[9:0]);
                end
            end
        end
    end

    // Advance one clock and drop all one-cycle strobes.
    task automatic tick();
        @(posedge Clk);
        #1;
        adcValid = 1'b0;
        arm      = 1'b0;
        rd_req   = 1'b0;
        st_req   = 1'b0;
    endtask

    task automatic issue_rd(input logic [9:0] a, input logic [7:0] e);
        rdAddr = a;
        rd_req = 1'b1;
        rd_q.push_back({a, e});
    endtask

    task automatic issue_st(input logic fr, input logic b, input logic [9:0] c);
        st_req = 1'b1;
        st_q.push_back({fr, b, c});
    endtask

    task automatic send(input logic [7:0] d);
        adcData  = d;
        adcValid = 1'b1;
        tick();
    endtask

    initial begin
        vgaRst = 1'b0; adcData = 8'd0; adcValid = 1'b0; trigLevel = 8'd128;
        arm = 1'b0; rdAddr = 10'd0;
        tick(); tick();
        // Reset state
        issue_rd(10'd0, 8'd0);
        issue_st(1'b0, 1'b0, 10'd0);
        tick();
        vgaRst = 1'b1;
        tick();

        // Ramp capture with an ignored arm at count 300
        arm = 1'b1;
        tick();
        issue_st(1'b0, 1'b1, 10'd0);
        tick();
        for (int i = 0; i <= 427; i++) send(8'(i));
        issue_st(1'b0, 1'b1, 10'd300);
        arm = 1'b1;
        tick();
        for (int i = 428; i <= 767; i++) send(8'(i));
        issue_st(1'b1, 1'b0, 10'd640);
        tick();
        // Samples in DONE must not be written
        for (int i = 0; i < 8; i++) send(8'd7);
        issue_st(1'b1, 1'b0, 10'd640);
        issue_rd(10'd0, 8'd128);   tick();
        issue_rd(10'd1, 8'd129);   tick();
        issue_rd(10'd127, 8'd255); tick();
        issue_rd(10'd128, 8'd0);   tick();
        issue_rd(10'd639, 8'd255); tick();
        issue_rd(10'd1023, 8'd0);  tick();
        // Back-to-back in-range then out-of-range read
        issue_rd(10'd5, 8'd133);   tick();
        issue_rd(10'd700, 8'd0);   tick();
        tick();

        // Constant input above level: no rising crossing
        trigLevel = 8'd100;
        arm = 1'b1;
        tick();
        issue_st(1'b0, 1'b1, 10'd0);
        tick();
        for (int i = 0; i < 60; i++) send(8'd200);
        issue_st(1'b0, 1'b1, 10'd0);
        issue_rd(10'd0, 8'd128);
        tick();
        tick();

        // Reset mid-capture, then a fresh acquisition
        trigLevel = 8'd128;
        for (int i = 0; i <= 427; i++) send(8'(i));
        issue_st(1'b0, 1'b1, 10'd300);
        tick();
        vgaRst = 1'b0;
        tick();
        vgaRst = 1'b1;
        issue_st(1'b0, 1'b0, 10'd0);
        tick();
        trigLevel = 8'd10;
        arm = 1'b1;
        tick();
        for (int i = 0; i <= 10; i++) send(8'(i));
        issue_st(1'b0, 1'b1, 10'd1);
        tick();
        for (int i = 11; i <= 648; i++) begin
            if (i == 110) issue_rd(10'd100, 8'd228);   // same-cycle write: old word
            if (i == 111) issue_rd(10'd100, 8'd110);   // now the new word
            send(8'(i));
        end
        issue_st(1'b0, 1'b1, 10'd639);
        tick();
        send(8'd137);
        issue_st(1'b1, 1'b0, 10'd640);
        issue_rd(10'd0, 8'd10);    tick();
        issue_rd(10'd300, 8'd54);  tick();
        issue_rd(10'd639, 8'd137); tick();
        tick(); tick();

        n_tests++;
        if (rd_q.size() != 0 || st_q.size() != 0) begin
            n_fail++;
            $display("FAIL leftover: rd=%0d st=%0d expected 0 0", rd_q.size(), st_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/adc_trigger_capture.md
ADC_TRIGGER_CAPTURE -- requirements
Module: adc_trigger_capture

Interface
REQ-001 SHALL have parameter DEPTH, default 640, meaning number of samples per captured frame (one per VGA column).
REQ-002 SHALL have parameter TIMEOUT_SAMPLES, default 4095, meaning number of valid samples waited in ARMED before a forced capture (used only under REQ-024).
REQ-003 SHALL have port Clk  input  1  system clock; all logic on its rising edge.
REQ-004 SHALL have port vgaRst  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port adcData  input  8  unsigned ADC sample.
REQ-006 SHALL have port adcValid  input  1  one-cycle strobe qualifying adcData.
REQ-007 SHALL have port trigLevel  input  8  rising-edge trigger threshold.
REQ-008 SHALL have port arm  input  1  one-cycle request to start a new acquisition.
REQ-009 SHALL have port rdAddr  input  10  display-side read address (column).
REQ-010 SHALL have port rdData  output  8  registered buffer word at rdAddr.
REQ-011 SHALL have port frameReady  output  1  high while a complete frame is held.
REQ-012 SHALL have port busy  output  1  high in ARMED or CAPTURE.
REQ-013 SHALL have port adcToVgaCount  output  10  number of samples written in the current frame.

Function
REQ-014 SHALL implement states IDLE, ARMED, CAPTURE, DONE; IDLE->ARMED on arm; DONE->ARMED on arm; arm ignored in ARMED and CAPTURE.
REQ-015 SHALL on entering ARMED clear adcToVgaCount and the prev-sample-valid flag; the first adcValid after arming only loads the previous-sample register and never triggers.
REQ-016 SHALL in ARMED detect a trigger on an adcValid cycle when prev < trigLevel and adcData >= trigLevel (8-bit unsigned compare), then write adcData to address 0, set adcToVgaCount=1, and go to CAPTURE.
REQ-017 SHALL in CAPTURE write each adcValid sample to address adcToVgaCount and increment it; the write making adcToVgaCount==DEPTH moves to DONE in the same cycle.
REQ-018 SHALL in DONE accept no writes, hold adcToVgaCount==DEPTH and drive frameReady=1; frameReady drops the cycle after arm is sampled.
REQ-019 SHALL drive rdData one cycle after rdAddr (registered read); rdAddr >= DEPTH returns 8'd0.
REQ-020 SHALL allow reads in any state; reads during CAPTURE return whatever the addressed word currently holds (mixed frame permitted).
REQ-021 SHALL when a write and a read target the same address in one cycle return the old word.
REQ-022 SHALL store samples unmodified (no inversion or offset; the display stage owns scaling).

Reset
REQ-023 SHALL when vgaRst is low at a rising Clk edge force state IDLE, rdData=0, frameReady=0, busy=0, adcToVgaCount=0, prev register 0, timeout counter 0; buffer contents are not cleared; reset mid-capture abandons the frame.

Configuration
REQ-024 SHALL with macro ADC_TRIG_TIMEOUT_EN defined count adcValid samples in ARMED and, when the count reaches TIMEOUT_SAMPLES without a trigger, treat the next adcValid as a trigger (auto mode); without the macro ARMED waits indefinitely and no counter is synthesized.

Verification
REQ-025 SHALL cover: arm, trigLevel=128, ramp 0..255 step 1 on adcValid -> word 0 = 128, word 639 = 255 then wraps to 0..., frameReady=1, adcToVgaCount=640.
REQ-026 SHALL cover: arm, first sample 200 then 200 constant, trigLevel=100 -> no trigger, busy stays 1, frameReady 0 (with macro: forced capture after 4095 samples, words all 200).
REQ-027 SHALL cover: arm pulse during CAPTURE at count 300 -> ignored, frame completes normally at 640.
REQ-028 SHALL cover: vgaRst low at count 300, then arm and new ramp -> state restarts, adcToVgaCount counts from 1, frameReady only after 640 new samples.
REQ-029 SHALL cover: in DONE read rdAddr=5 then 700 -> rdData equals word 5 one cycle later, then 0.
